// File: rtl/console_uart_tx_pkg.sv
// Shared constants and state encodings for the console UART transmitter.
// Imported by console_uart_tx and its FIFO.
package console_uart_tx_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned UART_STATE_LEN  = 2;
    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_DATA_BITS  = 8;

    localparam logic [UART_STATE_LEN-1:0] UART_IDLE  = 2'd0;
    localparam logic [UART_STATE_LEN-1:0] UART_START = 2'd1;
    localparam logic [UART_STATE_LEN-1:0] UART_DATA  = 2'd2;
    localparam logic [UART_STATE_LEN-1:0] UART_STOP  = 2'd3;

    typedef enum logic [UART_STATE_LEN-1:0] {
        StIdle  = UART_IDLE,
        StStart = UART_START,
        StData  = UART_DATA,
        StStop  = UART_STOP
    } uart_state_e;

    // Line level the transmitter drives while in a given state.
    function automatic logic uart_line_level(input uart_state_e st, input logic data_bit);
        logic lvl;
        lvl = 1'b1;
        unique case (st)
            StStart: lvl = 1'b0;
            StData:  lvl = data_bit;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous byte FIFO for the console port; combinational read of the head entry.
// A push is accepted when not full or when a pop happens on the same edge.
module console_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/console_uart_tx.sv
// Console port controller: queues bytes written by the core and sends them as 8N1 UART frames.
// drained tells the system when every queued byte has left the line.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          console_we,
    input  logic [XLEN-1:0]               console_wdata,
    output logic                          tx,
    output logic                          busy,
    output logic                          drained,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;
    logic          bcnt_end;
    logic          pop;

    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    logic          unused_wdata;
    assign unused_wdata = ^console_wdata[XLEN-1:8];

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (console_we),
        .pop     (pop),
        .din     (console_wdata[7:0]),
        .dout    (fifo_dout),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bcnt_end = (bcnt_q == BCNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bcnt_q     <= '0;
            bidx_q     <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            bidx_q     <= bidx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    bcnt_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bcnt_end) begin
                    bcnt_d  = '0;
                    bidx_d  = '0;
                    state_d = StData;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            StData: begin
                if (bcnt_end) begin
                    bcnt_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bidx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bcnt_end) begin
                    bcnt_d = '0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        overflow_d = overflow_q | (console_we & fifo_full & ~pop);
    end

    // tx is computed from next state so the registered line changes on the state edge.
    always_comb begin
        tx_d       = uart_line_level(state_d, shreg_d[0]);
        busy       = (state_q != StIdle);
        drained    = fifo_empty && (state_q == StIdle);
        tx         = tx_q;
        overflow   = overflow_q;
        fifo_count = fifo_cnt;
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Self-checking bench for console_uart_tx: a line receiver decodes frames and compares them
// against a queue of bytes expected to be transmitted.
module tb_console_uart_tx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        console_we;
    logic [31:0] console_wdata;
    logic        tx, busy, drained, overflow;
    logic [4:0]  fifo_count;

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] sb_q [$];

    console_uart_tx #(
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .tx            (tx),
        .busy          (busy),
        .drained       (drained),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic put(input logic [31:0] d, input bit keep);
        @(negedge clk);
        console_we    = 1'b1;
        console_wdata = d;
        if (keep) sb_q.push_back(d[7:0]);
    endtask

    task automatic idle_we();
        @(negedge clk);
        console_we    = 1'b0;
        console_wdata = '0;
    endtask

    task automatic wait_drained(input int max_cycles);
        int k;
        k = 0;
        while (drained !== 1'b1 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain_in_time", drained, 1);
    endtask

    // Line receiver: start detected at the first falling-edge sample, bits sampled mid-bit.
    logic       rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_sh   = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == CPB / 2) check_eq("rx_start", tx, 0);
            for (int i = 0; i < 8; i++) begin
                if (rx_cnt == CPB * (i + 1) + CPB / 2) rx_sh[i] <= tx;
            end
            if (rx_cnt == CPB * 9 + CPB / 2) check_eq("rx_stop", tx, 1);
            if (rx_cnt == FRAME - 1) begin
                rx_busy <= 1'b0;
                check_eq("rx_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check_eq("rx_byte", rx_sh, sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, busy_cyc, peak;
        logic [9:0] f;

        reset_n       = 1'b0;
        console_we    = 1'b0;
        console_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_drained", drained, 1);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_count", fifo_count, 0);
        reset_n = 1'b1;

        // Idle after reset release
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("t1_tx_lows", lows, 0);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_drained", drained, 1);
        check_eq("t1_count", fifo_count, 0);

        // Single byte 0x41, exact per-cycle waveform
        f = {1'b1, 8'h41, 1'b0};
        put(32'h41, 1);
        idle_we();
        @(posedge clk);
        #1;
        for (int c = 0; c < FRAME; c++) begin
            check_eq("t2_tx", tx, f[c / CPB]);
            if (c == FRAME - 1) check_eq("t2_drained_early", drained, 0);
            @(posedge clk);
            #1;
        end
        check_eq("t2_drained", drained, 1);
        check_eq("t2_busy", busy, 0);
        check_eq("t2_tx_idle", tx, 1);

        // Two bytes on consecutive cycles, no gap between frames
        put(32'h48, 1);
        put(32'h69, 1);
        idle_we();
        busy_cyc = 0;
        peak     = 0;
        repeat (100) begin
            if (busy === 1'b1) busy_cyc++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            @(negedge clk);
        end
        check_eq("t3_busy_cycles", busy_cyc, 2 * FRAME);
        check_eq("t3_count_peak", peak, 1);
        check_eq("t3_drained", drained, 1);

        // Overflow: 20 writes, 17 retained
        for (int i = 0; i < 20; i++) put(32'hC0 + i, i < 17);
        idle_we();
        check_eq("t4_overflow", overflow, 1);
        check_eq("t4_count_full", fifo_count, DEPTH);
        wait_drained(17 * FRAME + 50);
        check_eq("t4_overflow_sticky", overflow, 1);
        check_eq("t4_sb_empty", sb_q.size(), 0);

        // Upper data bits ignored
        put(32'hDEADBE55, 1);
        idle_we();
        wait_drained(FRAME + 20);
        check_eq("t5_sb_empty", sb_q.size(), 0);
        check_eq("t5_overflow_sticky", overflow, 1);

        // Reset during data bit 3 with two bytes queued
        put(32'hA1, 0);
        put(32'hA2, 0);
        put(32'hA3, 0);
        idle_we();
        repeat (16) @(negedge clk);
        check_eq("t6_busy_before", busy, 1);
        check_eq("t6_count_before", fifo_count, 2);
        check_eq("t6_tx_before", tx, 0);
        reset_n = 1'b0;
        #1;
        check_eq("t6_tx_abort", tx, 1);
        check_eq("t6_count", fifo_count, 0);
        check_eq("t6_overflow", overflow, 0);
        check_eq("t6_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("t6_no_frames", lows, 0);
        check_eq("t6_drained", drained, 1);
        check_eq("final_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
